stream_test_source: RTL
=======================

Name: stream_test_source

Overview:
- Upstream traffic stage for the 40G UDP parser rate-control path; output drives the rate controller's input AXIS port (tdata/tuser/tstrb/tlast plus tag).
- On `start`, emits in order:
  - one CONFIG flit (tag 0xC0) carrying D/N/P/Q/F;
  - `cfg_pkts` DATA packets (tag 0x5F) of P bytes each;
  - one NULL flit (tag 0) after every packet.
- Honours back-pressure and inserts D idle cycles between accepted flits.

Parameters:
- C_AXIS_TDATA_WIDTH, 256, data width; fixed at 256 (32 bytes/flit); other values unsupported.
- MAX_PKTS_W, 16, width of packet-count configuration and status.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse; begins a run when idle
- cfg_d  in  32  idle cycles after each accepted flit
- cfg_n  in  32  explosion coefficient; passed through in config flit
- cfg_p  in  32  packet size, bytes
- cfg_q  in  32  payload size; passed through
- cfg_f  in  32  filtered size; passed through
- cfg_pkts  in  MAX_PKTS_W  number of data packets per run
- out_tready  in  1  downstream ready
- out_tvalid  out  1  flit valid
- out_tdata  out  256  flit data
- out_tuser  out  128  valid byte count of flit, zero-extended
- out_tstrb  out  32  byte strobes
- out_tlast  out  1  last flit of packet / config / null
- out_tag  out  32  0xC0 config, 0x5F data, 0x00 null
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after final NULL flit accepted
- cfg_err  out  1  one-cycle pulse when start is rejected
- pkt_count  out  MAX_PKTS_W  packets completed in current/last run

Behaviour:
- Reset:
  - all outputs 0; state IDLE; counters 0.
  - Reset mid-run aborts immediately: out_tvalid drops in the same clock edge, no done pulse.
- Configuration capture: cfg_* sampled into internal registers on an accepted `start`; later changes are ignored until the next run.
- Start handling:
  - start while busy: ignored.
  - start with cfg_p==0 or cfg_pkts==0: rejected; cfg_err pulses the next cycle; stays IDLE.
- Flit count: flits = ceil(P/32) = (P>>5) + (P[4:0]!=0); rem = P[4:0].
- States:
  - IDLE: out_tvalid=0. Valid start -> CFG.
  - CFG: out_tvalid=1, tag 0xC0, tdata[31:0]=D, [63:32]=N, [95:64]=P, [127:96]=Q, [159:128]=F, rest 0; tstrb all ones; tuser 32; tlast=1. On handshake -> GAP, next=DATA.
  - DATA:
    - tag 0x5F; tdata from payload generator.
    - non-final flit: tstrb all ones, tuser 32, tlast 0.
    - final flit (flit_cnt==flits-1): tlast 1; tstrb = low rem bits set (all ones if rem==0); tuser = rem (32 if rem==0); tdata bytes above rem zeroed.
    - On each handshake -> GAP, next = DATA, or NULL after the final flit.
  - NULL: tag 0, tdata/tstrb/tuser 0, tlast 1. On handshake pkt_count++; -> GAP, next=DATA if pkt_count+1<cfg_pkts, else DONE.
  - GAP: out_tvalid=0 for exactly D cycles, then -> next. D==0 skips GAP (zero-cycle, back-to-back flits).
  - DONE: done=1 for one cycle; busy=0 next cycle; -> IDLE.
- AXIS rules:
  - Once out_tvalid rises, it and all payload/tag/last fields stay stable until out_tready=1.
  - out_tvalid never depends combinationally on out_tready.
  - Transfer = out_tvalid & out_tready.
- busy: 1 from the cycle after an accepted start through the DONE cycle.
- Latency: start -> CFG flit valid in 1 cycle.
- Counters: 32-bit; D up to 2^32-1 with no wrap during count; pkt_count saturates at 2^MAX_PKTS_W-1.
- Payload (default):
  - 8 lanes of 32-bit word; lane i = base+i.
  - base starts at 0 per run and advances by 8 per accepted data flit.
  - Wraps modulo 2^32.

Optional Feature:
- Macro SRC_PAYLOAD_LFSR_EN.
- Defined: each 32-bit lane comes from a 32-bit Galois LFSR (poly 0x80200003, seed 0xACE1_0000+run index); the LFSR advances 8 steps per accepted data flit.
- Undefined: incrementing-counter payload as above; no LFSR logic synthesised.

Decomposition:
- Package rc_stream_pkg:
  - TAG_CONFIG=32'hC0, TAG_DATA=32'h5F, TAG_NULL=32'h0;
  - BYTES_PER_FLIT=32;
  - state enum {IDLE,CFG,DATA,NULL,GAP,DONE};
  - config-flit field offsets.
  - Shared with the rate controller and its bench.
- One sub-module: stream_payload_gen (counter/LFSR lanes, advance and clear inputs, byte-mask of final flit).

Test Plan:
- D=0,N=1,P=64,F=64,pkts=1, out_tready=1: exact output sequence below; done pulses one cycle after the NULL flit is accepted.
  - CFG flit with tdata[95:64]=64.
  - 2 data flits: lanes 0..7 then 8..15; second has tlast=1, tstrb=FFFFFFFF, tuser=32.
  - NULL flit with tag 0, tlast 1.
- P=40, pkts=2: each packet is 2 flits; final flit tuser=8, tstrb=0x000000FF, tdata[255:64]=0; pkt_count ends at 2.
- D=3: out_tvalid low exactly 3 cycles after each handshake; 0 idle cycles when D=0.
- out_tready held low 5 cycles mid-packet: out_tvalid/tdata/tag/tlast stable throughout; no flit lost or duplicated.
- Rejected starts:
  - start with cfg_p=0 -> cfg_err pulse, busy stays 0.
  - start during a run -> ignored; sequence unchanged.
- Reset asserted during DATA flit 1 of packet 2: next cycle all outputs 0, no done pulse; a new start replays from the CFG flit with payload base 0.

Source files
------------

// File: rtl/rc_stream_pkg.sv
// rc_stream_pkg: tags, state encoding and config-flit layout shared by the rate-control stream path.
// LFSR constants and helper exist only when SRC_PAYLOAD_LFSR_EN is defined.
package rc_stream_pkg;
  localparam logic [31:0] TAG_CONFIG = 32'hC0;
  localparam logic [31:0] TAG_DATA = 32'h5F;
  localparam logic [31:0] TAG_NULL = 32'h0;
  localparam int BYTES_PER_FLIT = 32;
  localparam int CFG_D_LSB = 0;
  localparam int CFG_N_LSB = 32;
  localparam int CFG_P_LSB = 64;
  localparam int CFG_Q_LSB = 96;
  localparam int CFG_F_LSB = 128;
  typedef enum logic [2:0] {IDLE, CFG, DATA, NULL, GAP, DONE} state_t;
`ifdef SRC_PAYLOAD_LFSR_EN
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'hACE10000;
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = r[0] ? (r >> 1) ^ LFSR_POLY : r >> 1;
    return r;
  endfunction
`endif
endpackage

// File: rtl/stream_payload_gen.sv
// stream_payload_gen: 8x32-bit lane payload (counter, or Galois LFSR under SRC_PAYLOAD_LFSR_EN)
// with byte masking of a packet's final partial flit.
module stream_payload_gen
  import rc_stream_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  input  logic         last,
  input  logic [4:0]   rem,
`ifdef SRC_PAYLOAD_LFSR_EN
  input  logic [31:0]  seed,
`endif
  output logic [255:0] data,
  output logic [31:0]  strb
);
  logic [31:0] base;
  logic [255:0] raw;
`ifdef SRC_PAYLOAD_LFSR_EN
  always_ff @(posedge clk) base <= reset ? '0 : clear ? seed : advance ? lfsr_adv(base, 8) : base;
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign raw[32*i+:32] = lfsr_adv(base, i);
  end
`else
  always_ff @(posedge clk) base <= reset || clear ? '0 : advance ? base + 32'd8 : base;
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign raw[32*i+:32] = base + 32'(i);
  end
`endif
  assign strb = last && rem != 5'd0 ? (32'd1 << rem) - 32'd1 : '1;
  for (genvar j = 0; j < 32; j++) begin : g_byte
    assign data[8*j+:8] = strb[j] ? raw[8*j+:8] : 8'h0;
  end
endmodule

// File: rtl/stream_test_source.sv
// stream_test_source: emits CONFIG, then cfg_pkts DATA packets each followed by a NULL flit, with D idle cycles
// after every accepted flit. SRC_PAYLOAD_LFSR_EN selects LFSR payload instead of the counter.
module stream_test_source
  import rc_stream_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 256,
  parameter int MAX_PKTS_W = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [31:0]                     cfg_d,
  input  logic [31:0]                     cfg_n,
  input  logic [31:0]                     cfg_p,
  input  logic [31:0]                     cfg_q,
  input  logic [31:0]                     cfg_f,
  input  logic [MAX_PKTS_W-1:0]           cfg_pkts,
  input  logic                            out_tready,
  output logic                            out_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   out_tdata,
  output logic [127:0]                    out_tuser,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] out_tstrb,
  output logic                            out_tlast,
  output logic [31:0]                     out_tag,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err,
  output logic [MAX_PKTS_W-1:0]           pkt_count
);
  state_t state, state_n, after, target;
  logic [31:0] d_r, n_r, p_r, q_r, f_r, gap_cnt, flit_cnt, flits;
  logic [MAX_PKTS_W-1:0] pkts_r;
  logic [MAX_PKTS_W:0] pc1;
  logic ok_start, hs, last, more;
  logic [255:0] gen_data, cfg_flit;
  logic [31:0] gen_strb;
  logic [7:0] ucnt;
  assign ok_start = state == IDLE && start && cfg_p != '0 && cfg_pkts != '0;
  assign hs = out_tvalid && out_tready;
  assign flits = {5'b0, p_r[31:5]} + {31'b0, |p_r[4:0]};
  assign last = flit_cnt == flits - 32'd1;
  assign pc1 = {1'b0, pkt_count} + 1'b1;
  assign more = pc1 < {1'b0, pkts_r};
  assign target = state == NULL ? (more ? DATA : DONE) : (state == DATA && last) ? NULL : DATA;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:            state_n = ok_start ? CFG : IDLE;
      CFG, DATA, NULL: state_n = hs ? (d_r == '0 ? target : GAP) : state;
      GAP:             state_n = gap_cnt == 32'd1 ? after : GAP;
      DONE:            state_n = IDLE;
      default:         state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      after <= DATA;
      {d_r, n_r, p_r, q_r, f_r, gap_cnt, flit_cnt} <= '0;
      pkts_r <= '0;
      pkt_count <= '0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      cfg_err <= state == IDLE && start && !ok_start;
      if (ok_start) begin
        {d_r, n_r, p_r, q_r, f_r} <= {cfg_d, cfg_n, cfg_p, cfg_q, cfg_f};
        pkts_r <= cfg_pkts;
        pkt_count <= '0;
        flit_cnt <= '0;
      end
      if (hs) begin
        after <= target;
        gap_cnt <= d_r;
      end else if (state == GAP) gap_cnt <= gap_cnt - 32'd1;
      if (hs && state == DATA) flit_cnt <= last ? '0 : flit_cnt + 32'd1;
      if (hs && state == NULL && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
    end
  end
`ifdef SRC_PAYLOAD_LFSR_EN
  logic [31:0] run_idx;
  always_ff @(posedge clk) run_idx <= reset ? '0 : ok_start ? run_idx + 32'd1 : run_idx;
`endif
  stream_payload_gen u_gen (
    .clk(clk), .reset(reset), .clear(ok_start), .advance(hs && state == DATA),
    .last(last), .rem(p_r[4:0]),
`ifdef SRC_PAYLOAD_LFSR_EN
    .seed(LFSR_SEED + run_idx),
`endif
    .data(gen_data), .strb(gen_strb)
  );
  always_comb begin
    cfg_flit = '0;
    cfg_flit[CFG_D_LSB+:32] = d_r;
    cfg_flit[CFG_N_LSB+:32] = n_r;
    cfg_flit[CFG_P_LSB+:32] = p_r;
    cfg_flit[CFG_Q_LSB+:32] = q_r;
    cfg_flit[CFG_F_LSB+:32] = f_r;
  end
  assign ucnt = state == DATA && last && p_r[4:0] != 5'd0 ? {3'b0, p_r[4:0]} :
                state == CFG || state == DATA ? 8'(BYTES_PER_FLIT) : 8'd0;
  assign out_tvalid = state == CFG || state == DATA || state == NULL;
  assign out_tdata = state == CFG ? cfg_flit : state == DATA ? gen_data : '0;
  assign out_tstrb = state == CFG ? '1 : state == DATA ? gen_strb : '0;
  assign out_tuser = {120'b0, ucnt};
  assign out_tlast = state == CFG || state == NULL || (state == DATA && last);
  assign out_tag = state == CFG ? TAG_CONFIG : state == DATA ? TAG_DATA : TAG_NULL;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
